// File: rtl/fp_norm_round.sv
// fp_norm_round -- normalize and round stage of a single-precision FP adder.
//
// Takes the 33-bit mantissa magnitude M = {cout, sum} (binary point below
// bit 30), the biased exponent and sign of the aligned operands, and produces
// a packed IEEE-754 single with round-to-nearest-even. Denormals are not
// produced: underflow flushes to signed zero, overflow saturates to infinity.
//
// Pipeline (no backpressure, one input per cycle, three register stages):
//   stage 1: register M, E, S, valid and k = leading-one position of M
//   stage 2: shift M so the leading one sits at bit 30, adjust exponent,
//            collect right-shifted-out bits into sticky
//   stage 3: round to nearest even, detect overflow/underflow/zero
//
// Ports:
//   clk       in   rising-edge clock
//   clear     in   synchronous active-high reset, empties the pipeline
//   in_valid  in   sum/cout/E/S hold a result from the mantissa adder
//   sum       in   32-bit mantissa magnitude (bit 30 = weight 1.0)
//   cout      in   carry-out of the mantissa add (bit 32 of M)
//   E         in   8-bit biased exponent
//   S         in   result sign
//   out_valid out  result and flags hold a valid single
//   result    out  {sign, exp[7:0], frac[22:0]}, 0 when out_valid is low
//   ovf       out  exponent overflow, result is signed infinity
//   unf       out  exponent underflow, result is signed zero
//   zero      out  M was zero, result is +0
module fp_norm_round (
  input  logic        clk,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [31:0] sum,
  input  logic        cout,
  input  logic [7:0]  E,
  input  logic        S,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        zero
);

  // ---------------------------------------------------------------- stage 1
  logic [32:0] m_in;
  logic [5:0]  lead_k;

  assign m_in = {cout, sum};

  // Highest set bit wins; M = 0 leaves k = 0, which is harmless because the
  // zero flag overrides everything downstream.
  always_comb begin
    lead_k = 6'd0;
    for (int i = 0; i < 33; i++) begin
      if (m_in[i]) lead_k = 6'(i);
    end
  end

  logic        v1_reg;
  logic [32:0] m1_reg;
  logic [7:0]  e1_reg;
  logic        s1_reg;
  logic [5:0]  k1_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      v1_reg <= 1'b0;
      m1_reg <= '0;
      e1_reg <= '0;
      s1_reg <= 1'b0;
      k1_reg <= '0;
    end else begin
      v1_reg <= in_valid;
      m1_reg <= m_in;
      e1_reg <= E;
      s1_reg <= S;
      k1_reg <= lead_k;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [32:0]       n_next;
  logic              sticky_next;
  logic signed [9:0] exp2_next;
  logic [5:0]        lsh;

  // Exponent is carried as 10-bit signed so E+2 and E-30 never wrap.
  always_comb begin
    n_next      = m1_reg;
    sticky_next = 1'b0;
    exp2_next   = $signed({2'b00, e1_reg});
    lsh         = 6'd0;
    if (k1_reg == 6'd32) begin
      n_next      = m1_reg >> 2;
      sticky_next = |m1_reg[1:0];
      exp2_next   = $signed({2'b00, e1_reg}) + 10'sd2;
    end else if (k1_reg == 6'd31) begin
      n_next      = m1_reg >> 1;
      sticky_next = m1_reg[0];
      exp2_next   = $signed({2'b00, e1_reg}) + 10'sd1;
    end else if (k1_reg < 6'd30) begin
      lsh       = 6'd30 - k1_reg;
      n_next    = m1_reg << lsh;
      exp2_next = $signed({2'b00, e1_reg}) - $signed({4'b0000, lsh});
    end
  end

  logic              v2_reg;
  logic [29:0]       n2_reg;     // bits below the hidden one
  logic              sticky2_reg;
  logic signed [9:0] exp2_reg;
  logic              s2_reg;
  logic              zero2_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      v2_reg      <= 1'b0;
      n2_reg      <= '0;
      sticky2_reg <= 1'b0;
      exp2_reg    <= '0;
      s2_reg      <= 1'b0;
      zero2_reg   <= 1'b0;
    end else begin
      v2_reg      <= v1_reg;
      n2_reg      <= n_next[29:0];
      sticky2_reg <= sticky_next;
      exp2_reg    <= exp2_next;
      s2_reg      <= s1_reg;
      zero2_reg   <= (m1_reg == 33'd0);
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [22:0]       frac;
  logic              guard;
  logic              sticky_all;
  logic              round_inc;
  logic [23:0]       frac_rnd;
  logic signed [9:0] exp3;
  logic              out_valid_next;
  logic [31:0]       result_next;
  logic              ovf_next;
  logic              unf_next;
  logic              zero_next;

  assign frac       = n2_reg[29:7];
  assign guard      = n2_reg[6];
  assign sticky_all = sticky2_reg | (|n2_reg[5:0]);
  // Ties (guard set, nothing below) round up only when the lsb is odd.
  assign round_inc  = guard & (sticky_all | n2_reg[7]);
  assign frac_rnd   = {1'b0, frac} + {23'd0, round_inc};
  // An all-ones fraction rolling over leaves frac_rnd[22:0] = 0 and bumps
  // the exponent by one.
  assign exp3       = exp2_reg + $signed({9'd0, frac_rnd[23]});

  always_comb begin
    out_valid_next = v2_reg;
    result_next    = 32'h0;
    ovf_next       = 1'b0;
    unf_next       = 1'b0;
    zero_next      = 1'b0;
    if (v2_reg) begin
      if (zero2_reg) begin
        zero_next = 1'b1;
      end else if (exp3 >= 10'sd255) begin
        ovf_next    = 1'b1;
        result_next = {s2_reg, 8'hFF, 23'h0};
      end else if (exp3 <= 10'sd0) begin
        unf_next    = 1'b1;
        result_next = {s2_reg, 31'h0};
      end else begin
        result_next = {s2_reg, exp3[7:0], frac_rnd[22:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid <= 1'b0;
      result    <= 32'h0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= out_valid_next;
      result    <= result_next;
      ovf       <= ovf_next;
      unf       <= unf_next;
      zero      <= zero_next;
    end
  end

endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: clear  input  1  reset, synchronous, active-high.
REQ-003 SHALL: in_valid  input  1  high when sum/cout/E/S carry a result from the mantissa adder stage.
REQ-004 SHALL: sum  input  32  unsigned mantissa magnitude; binary point below bit 30 (bit 30 = hidden-one weight 1.0).
REQ-005 SHALL: cout  input  1  carry-out of the mantissa add; forms 33-bit magnitude M = {cout,sum}.
REQ-006 SHALL: E  input  8  biased exponent of the aligned operands.
REQ-007 SHALL: S  input  1  result sign.
REQ-008 SHALL: out_valid  output  1  high when result and flags hold a valid IEEE-754 single.
REQ-009 SHALL: result  output  32  packed {sign, exp[7:0], frac[22:0]}.
REQ-010 SHALL: ovf  output  1  exponent overflow; result forced to infinity.
REQ-011 SHALL: unf  output  1  exponent underflow; result flushed to signed zero.
REQ-012 SHALL: zero  output  1  M was zero.

Function
REQ-013 SHALL: fixed 3-stage pipeline without backpressure; a new input is accepted every cycle.
REQ-014 SHALL: inputs sampled at edge n emerge after edge n+3; out_valid(n+3) = in_valid(n).
REQ-015 SHALL: stage 1 registers M, E, S, valid and k = position of the leading one of M (0..32).
REQ-016 SHALL: stage 2, k>30: right-shift M by d=k-30 (1 or 2), exponent = E+d, shifted-out bits ORed into sticky.
REQ-017 SHALL: stage 2, k<30: left-shift M by d=30-k, exponent = E-d, sticky = 0.
REQ-018 SHALL: stage 2, k=30: no shift, exponent = E.
REQ-019 SHALL: exponent arithmetic uses 10-bit signed width; no wrap-around.
REQ-020 SHALL: stage 3 rounds the normalized N to nearest-even: frac = N[29:7], guard = N[6], sticky' = sticky | (|N[5:0]); increment when guard & (sticky' | N[7]).
REQ-021 SHALL: a rounding carry out of frac (all ones + 1) gives frac=0 and exponent+1.
REQ-022 SHALL: final exponent >= 255 gives result = {S,8'hFF,23'h0} and ovf=1.
REQ-023 SHALL: final exponent <= 0 with M nonzero gives result = {S,31'h0} and unf=1; no denormals.
REQ-024 SHALL: M = 0 gives result = 32'h0000_0000 and zero=1, regardless of S and E.
REQ-025 SHALL: ovf, unf and zero are mutually exclusive and are 0 whenever out_valid=0.
REQ-026 SHALL: when out_valid=0, result holds 32'h0.
REQ-027 SHALL: invalid slots (in_valid=0) flow through as bubbles; data in them is don't-care internally.

Reset
REQ-028 SHALL: clear=1 at a rising edge zeroes every pipeline register, so out_valid, result, ovf, unf and zero read 0 after that edge.
REQ-029 SHALL: clear discards in-flight items; an item sampled in the same edge as clear is lost.
REQ-030 SHALL: clear has priority over in_valid; the first accepted input after release appears 3 edges later.

Verification
REQ-031 SHALL: sum=32'h4000_0000, cout=0, E=127, S=0 -> 3 edges later result=32'h3F80_0000, flags 0.
REQ-032 SHALL: sum=32'h8000_0000, E=127 -> 32'h4000_0000; sum=32'h1000_0000, E=127 -> 32'h3E80_0000.
REQ-033 SHALL: rounding: sum=32'h4000_00C0, E=127 -> 32'h3F80_0002; sum=32'h4000_0040 -> 32'h3F80_0000; sum=32'h7FFF_FFC0 -> 32'h4000_0000.
REQ-034 SHALL: limits: E=254, sum=32'h8000_0000 -> 32'h7F80_0000, ovf=1; E=1, S=1, sum=32'h2000_0000 -> 32'h8000_0000, unf=1; sum=0 -> zero=1.
REQ-035 SHALL: back-to-back: 8 consecutive valid inputs -> 8 consecutive out_valid cycles in order; in_valid pattern 1,0,1 -> out_valid 1,0,1.
REQ-036 SHALL: reset mid-flight: 2 items in pipeline, clear for 1 cycle -> no out_valid for either item; all outputs 0.
